// File: rtl/alu_pin_driver.sv
`timescale 1ns/1ps
// alu_pin_driver: host-side initiator for the pin-level ALU tile.
// Accepts a request, packs it onto two 8-bit pin buses, waits a programmable
// settle time, samples the tile result and returns it on a response port,
// comparing against a locally computed expected value for add/sub opcodes.
module alu_pin_driver #(
  parameter int unsigned SETTLE_CYCLES = 2  // legal range 1..15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_opcode,
  input  logic [5:0] req_op1,
  input  logic [5:0] req_op2,
  output logic [7:0] pin_a_out,
  output logic [7:0] pin_b_out,
  input  logic [7:0] pin_res_in,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_result,
  output logic       rsp_checked,
  output logic       rsp_mismatch,
  output logic       busy,
  output logic [7:0] err_count
);

  localparam logic [3:0] LP_CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_next_state;

  logic [3:0] r_cnt;
  logic [7:0] r_expected;
  logic       r_exp_defined;
  logic [7:0] r_pin_a;
  logic [7:0] r_pin_b;
  logic       r_rsp_valid;
  logic [7:0] r_rsp_result;
  logic       r_rsp_checked;
  logic       r_rsp_mismatch;
  logic [7:0] r_err_count;

  logic       w_accept;
  logic       w_sample;
  logic       w_mismatch;
  logic       w_exp_defined;
  logic [7:0] w_expected;

  // Ready only in IDLE and never while reset is held, so nothing is accepted
  // on the reset edge.
  assign req_ready = (r_state == ST_IDLE) && !rst;
  assign w_accept  = req_valid && req_ready;
  assign w_sample  = (r_state == ST_SETTLE) && (r_cnt == 4'd0);

  // Mismatch is only meaningful for opcodes with a defined expected value.
  assign w_mismatch = r_exp_defined && (pin_res_in != r_expected);

  // Expected result from the raw request (operands zero-extended, mod 256).
  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_expected    = 8'h00;
    w_exp_defined = 1'b0;
    case (req_opcode)
      4'd0: begin
        w_expected    = {2'b00, req_op1} + {2'b00, req_op2};
        w_exp_defined = 1'b1;
      end
      4'd1: begin
        w_expected    = {2'b00, req_op1} - {2'b00, req_op2};
        w_exp_defined = 1'b1;
      end
      default: ;
    endcase
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic: accept -> settle countdown -> hold response until taken.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept)  w_next_state = ST_SETTLE;
      ST_SETTLE: if (w_sample)  w_next_state = ST_RESP;
      ST_RESP:   if (rsp_ready) w_next_state = ST_IDLE;
      default:                  w_next_state = ST_IDLE;
    endcase
  end

  // Datapath: capture request and drive pins on accept, count down the
  // settle time, sample the tile result, and hold the response until taken.
  // Pins intentionally keep their last value between transactions.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt          <= 4'd0;
      r_expected     <= 8'h00;
      r_exp_defined  <= 1'b0;
      r_pin_a        <= 8'h00;
      r_pin_b        <= 8'h00;
      r_rsp_valid    <= 1'b0;
      r_rsp_result   <= 8'h00;
      r_rsp_checked  <= 1'b0;
      r_rsp_mismatch <= 1'b0;
      r_err_count    <= 8'h00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_pin_a       <= {req_op2[5:4], req_op1};
            r_pin_b       <= {req_opcode, req_op2[3:0]};
            r_expected    <= w_expected;
            r_exp_defined <= w_exp_defined;
            r_cnt         <= LP_CNT_LOAD;
          end
        end
        ST_SETTLE: begin
          if (w_sample) begin
            r_rsp_result   <= pin_res_in;
            r_rsp_checked  <= r_exp_defined;
            r_rsp_mismatch <= w_mismatch;
            r_rsp_valid    <= 1'b1;
            if (w_mismatch && (r_err_count != 8'hFF))
              r_err_count <= r_err_count + 8'd1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) r_rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign pin_a_out    = r_pin_a;
  assign pin_b_out    = r_pin_b;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_result   = r_rsp_result;
  assign rsp_checked  = r_rsp_checked;
  assign rsp_mismatch = r_rsp_mismatch;
  assign busy         = (r_state != ST_IDLE);
  assign err_count    = r_err_count;

endmodule

// File: tb/tb_alu_pin_driver.sv
`timescale 1ns/1ps
// Self-checking bench for alu_pin_driver: directed vector table, hand-written
// reset/backpressure sequences and randomized transactions against a model.
module tb_alu_pin_driver;

  localparam int SETTLE_A = 2;
  localparam int SETTLE_B = 4;

  typedef struct {
    logic [3:0] opcode;
    logic [5:0] op1;
    logic [5:0] op2;
    logic       fen;
    logic [7:0] fval;
    logic [7:0] exp_result;
    logic       exp_checked;
    logic       exp_mismatch;
    logic [7:0] exp_pin_a;
    logic [7:0] exp_pin_b;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A (SETTLE_CYCLES = 2)
  logic       rst, req_valid, req_ready, rsp_valid, rsp_ready;
  logic [3:0] req_opcode;
  logic [5:0] req_op1, req_op2;
  logic [7:0] pin_a_out, pin_b_out, pin_res_in, rsp_result, err_count;
  logic       rsp_checked, rsp_mismatch, busy;
  logic       force_en;
  logic [7:0] force_val;

  // DUT B (SETTLE_CYCLES = 4)
  logic       rst4, req_valid4, req_ready4, rsp_valid4, rsp_ready4;
  logic [3:0] req_opcode4;
  logic [5:0] req_op14, req_op24;
  logic [7:0] pin_a4, pin_b4, pin_res4, rsp_result4, err_count4;
  logic       rsp_checked4, rsp_mismatch4, busy4;

  alu_pin_driver #(.SETTLE_CYCLES(SETTLE_A)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_op1(req_op1), .req_op2(req_op2),
    .pin_a_out(pin_a_out), .pin_b_out(pin_b_out), .pin_res_in(pin_res_in),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_checked(rsp_checked), .rsp_mismatch(rsp_mismatch), .busy(busy),
    .err_count(err_count)
  );

  alu_pin_driver #(.SETTLE_CYCLES(SETTLE_B)) u_dut4 (
    .clk(clk), .rst(rst4), .req_valid(req_valid4), .req_ready(req_ready4),
    .req_opcode(req_opcode4), .req_op1(req_op14), .req_op2(req_op24),
    .pin_a_out(pin_a4), .pin_b_out(pin_b4), .pin_res_in(pin_res4),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4), .rsp_result(rsp_result4),
    .rsp_checked(rsp_checked4), .rsp_mismatch(rsp_mismatch4), .busy(busy4),
    .err_count(err_count4)
  );

  // Behavioural ALU tile: plain integer arithmetic per opcode.
  function automatic int tile_compute(input int opc, input int a, input int b);
    case (opc)
      0:       return (a + b) % 256;
      1:       return (a - b + 256) % 256;
      default: return (a * 3 + b + opc * 7) % 256;
    endcase
  endfunction

  // Tiles decode their inputs from the pins, which also exercises the packing.
  always_comb begin
    if (force_en) pin_res_in = force_val;
    else pin_res_in = 8'(tile_compute(int'(pin_b_out[7:4]), int'(pin_a_out[5:0]),
                                      int'({pin_a_out[7:6], pin_b_out[3:0]})));
    pin_res4 = 8'(tile_compute(int'(pin_b4[7:4]), int'(pin_a4[5:0]),
                               int'({pin_a4[7:6], pin_b4[3:0]})));
  end

  int n_checks = 0;
  int n_errors = 0;
  int err_model = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: expected outputs from the request and tile behaviour.
  function automatic vec_t make_vec(input int opc, input int a, input int b,
                                    input logic fen, input logic [7:0] fval);
    vec_t v;
    int   expv, res;
    v.opcode = 4'(opc); v.op1 = 6'(a); v.op2 = 6'(b);
    v.fen = fen; v.fval = fval;
    v.exp_checked = (opc < 2);
    expv = (opc == 0) ? (a + b) % 256 : (a - b + 256) % 256;
    res  = fen ? int'(fval) : tile_compute(opc, a, b);
    v.exp_result   = 8'(res);
    v.exp_mismatch = v.exp_checked && (res != expv);
    v.exp_pin_a    = 8'((b / 16) * 64 + a);
    v.exp_pin_b    = 8'(opc * 16 + (b % 16));
    return v;
  endfunction

  // One full transaction on DUT A with rdy_delay cycles of backpressure.
  task automatic do_txn(input vec_t v, input int rdy_delay);
    int lat;
    req_opcode = v.opcode; req_op1 = v.op1; req_op2 = v.op2;
    force_en = v.fen; force_val = v.fval;
    req_valid = 1'b1;
    for (int i = 0; i < 20 && !req_ready; i++) step();
    check("req_ready_before_accept", req_ready, 1);
    step();  // accept edge
    req_valid = 1'b0;
    req_opcode = ~v.opcode; req_op1 = ~v.op1; req_op2 = ~v.op2;
    check("pin_a_after_accept", pin_a_out, v.exp_pin_a);
    check("pin_b_after_accept", pin_b_out, v.exp_pin_b);
    check("busy_in_settle", busy, 1);
    check("req_ready_in_settle", req_ready, 0);
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      step();
      lat++;
    end
    check("latency", lat, SETTLE_A);
    check("rsp_result", rsp_result, v.exp_result);
    check("rsp_checked", rsp_checked, v.exp_checked);
    check("rsp_mismatch", rsp_mismatch, v.exp_mismatch);
    check("pin_a_hold", pin_a_out, v.exp_pin_a);
    if (v.exp_mismatch && err_model < 255) err_model++;
    check("err_count", err_count, err_model);
    // Perturb the tile while the response is held; outputs must not move.
    force_en = 1'b1; force_val = ~v.exp_result;
    for (int i = 0; i < rdy_delay; i++) begin
      step();
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_result", rsp_result, v.exp_result);
      check("bp_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    force_en = 1'b0;
    check("rsp_valid_after_take", rsp_valid, 0);
    check("req_ready_after_take", req_ready, 1);
    check("busy_after_take", busy, 0);
    check("pin_b_after_take", pin_b_out, v.exp_pin_b);
  endtask

  task automatic reset_a();
    rst = 1'b1; req_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_req_ready", req_ready, 0);
      check("rst_pin_a", pin_a_out, 0);
      check("rst_pin_b", pin_b_out, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_err_count", err_count, 0);
      check("rst_busy", busy, 0);
    end
    rst = 1'b0; req_valid = 1'b0;
    #1;
    check("req_ready_after_rst", req_ready, 1);
    err_model = 0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t dir_vecs[4];
    vec_t v;
    int   lat;

    dir_vecs[0] = '{4'd0, 6'd63, 6'd63, 1'b0, 8'h00, 8'h7E, 1'b1, 1'b0, 8'hFF, 8'h0F};
    dir_vecs[1] = '{4'd1, 6'd5,  6'd9,  1'b0, 8'h00, 8'hFC, 1'b1, 1'b0, 8'h05, 8'h19};
    dir_vecs[2] = '{4'd2, 6'd10, 6'd20, 1'b1, 8'h55, 8'h55, 1'b0, 1'b0, 8'h4A, 8'h24};
    dir_vecs[3] = '{4'd0, 6'd1,  6'd1,  1'b1, 8'h03, 8'h03, 1'b1, 1'b1, 8'h01, 8'h01};

    rsp_ready = 1'b0; force_en = 1'b0; force_val = 8'h00;
    req_opcode = 4'd0; req_op1 = 6'd0; req_op2 = 6'd0;
    rst4 = 1'b1; req_valid4 = 1'b0; rsp_ready4 = 1'b0;
    req_opcode4 = 4'd0; req_op14 = 6'd0; req_op24 = 6'd0;

    reset_a();
    rst4 = 1'b0;

    // Directed table; the first entry also exercises 5 cycles of backpressure.
    for (int i = 0; i < 4; i++) do_txn(dir_vecs[i], (i == 0) ? 5 : 0);

    // Saturation: 300 forced mismatches.
    for (int i = 0; i < 300; i++) do_txn(dir_vecs[3], 0);
    check("err_count_saturated", err_count, 255);

    // Reset clears the error counter.
    reset_a();

    // Randomized transactions.
    for (int i = 0; i < 60; i++) begin
      v = make_vec(int'($urandom_range(15)), int'($urandom_range(63)), int'($urandom_range(63)),
                   ($urandom_range(3) == 0), 8'($urandom_range(255)));
      do_txn(v, int'($urandom_range(3)));
    end

    // DUT B: reset in the middle of SETTLE aborts with no response.
    req_opcode4 = 4'd0; req_op14 = 6'd3; req_op24 = 6'd4; req_valid4 = 1'b1;
    check("b_req_ready_idle", req_ready4, 1);
    step();  // accept
    req_valid4 = 1'b0;
    check("b_pin_a", pin_a4, 8'h03);
    check("b_pin_b", pin_b4, 8'h04);
    step();
    rst4 = 1'b1;
    step();
    check("b_abort_rsp_valid", rsp_valid4, 0);
    check("b_abort_pin_a", pin_a4, 0);
    check("b_abort_pin_b", pin_b4, 0);
    check("b_abort_busy", busy4, 0);
    rst4 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("b_no_rsp_after_abort", rsp_valid4, 0);
    end
    check("b_idle_after_abort", req_ready4, 1);

    // DUT B: normal transaction with 4-cycle latency.
    req_opcode4 = 4'd1; req_op14 = 6'd2; req_op24 = 6'd7; req_valid4 = 1'b1;
    step();
    req_valid4 = 1'b0;
    lat = 0;
    while (!rsp_valid4 && lat < 40) begin
      step();
      lat++;
    end
    check("b_latency", lat, SETTLE_B);
    check("b_rsp_result", rsp_result4, 8'hFB);
    check("b_rsp_checked", rsp_checked4, 1);
    check("b_rsp_mismatch", rsp_mismatch4, 0);
    rsp_ready4 = 1'b1;
    step();
    rsp_ready4 = 1'b0;
    check("b_rsp_valid_taken", rsp_valid4, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_pin_driver.md
Name: alu_pin_driver

Overview:
Host-side initiator for the pin-level ALU command interface. It accepts an ALU request on a valid/ready port and packs the opcode and two 6-bit operands onto the two 8-bit pin buses the ALU tile reads. After a programmable settle time it samples the tile's 8-bit result bus and returns it on a valid/ready response port. It also computes the expected result for the defined opcodes, flags mismatches and keeps a saturating error count, which lets the block act as the on-chip self-check sequencer for the ALU tile.

Parameters:
SETTLE_CYCLES, 2, number of cycles the pin buses are held stable before the result is sampled; legal range 1..15; 4-bit counter.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  request valid
req_ready  out  1  request ready; high only in IDLE
req_opcode  in  4  ALU opcode
req_op1  in  6  operand 1
req_op2  in  6  operand 2
pin_a_out  out  8  to tile dedicated inputs: {op2[5:4], op1[5:0]}
pin_b_out  out  8  to tile bidir inputs: {opcode[3:0], op2[3:0]}
pin_res_in  in  8  from tile dedicated outputs (result)
rsp_valid  out  1  response valid
rsp_ready  in  1  response ready
rsp_result  out  8  sampled result
rsp_checked  out  1  opcode had a defined expected value (0 or 1)
rsp_mismatch  out  1  rsp_checked and rsp_result != expected
busy  out  1  state != IDLE
err_count  out  8  saturating mismatch count

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high (rst). Reset is sampled only on the rising edge of clk.
- Reset values: state IDLE; pin_a_out, pin_b_out = 0x00; rsp_valid = 0; rsp_result = 0x00; rsp_checked = 0; rsp_mismatch = 0; err_count = 0; settle counter = 0. Consequence: req_ready = 1 and busy = 0 in the cycle after reset.
- States:
  - IDLE: waiting for a request.
  - SETTLE: pins driven, counting down the settle time.
  - RESP: holding the response until it is taken.
- IDLE -> SETTLE on edge E0 where req_valid && req_ready.
  - At E0: opcode and operands are captured and the pins are registered per the packing above.
  - At E0: expected value is latched. opcode 0: (zext(op1) + zext(op2)) mod 256. opcode 1: (zext(op1) - zext(op2)) mod 256. Operands are zero-extended to 8 bits. Opcodes 2..15 have no expected value.
  - At E0: counter loads SETTLE_CYCLES-1.
- SETTLE: counter decrements each edge. On the edge where it is 0 (edge E_S, S = SETTLE_CYCLES after E0):
  - pin_res_in is sampled into rsp_result.
  - rsp_checked, rsp_mismatch and rsp_valid are set.
  - state -> RESP.
  - Request-to-response latency: rsp_valid is visible exactly SETTLE_CYCLES cycles after the accept cycle.
- err_count increments at E_S when mismatch = 1 and saturates at 255 (no wrap).
- RESP: all rsp_* outputs are held stable while rsp_valid && !rsp_ready. On the edge where rsp_ready = 1: rsp_valid -> 0 and state -> IDLE. req_ready rises the following cycle; there is no same-cycle re-accept. The minimum request period is SETTLE_CYCLES+2 cycles.
- Pins are never returned to 0 after a transaction. They hold the last driven values until the next accept, so the tile inputs do not glitch.
- Request inputs are sampled only at the accept edge. Changes afterwards are ignored. req_valid while not ready is not lost (the requester holds it).
- Reset in any state aborts the transaction with no response, clears err_count and returns all outputs to their reset values.
- rsp_checked = 0 implies rsp_mismatch = 0.

Test Plan:
- Reset: assert rst for 2 cycles with req_valid = 1 -> req_ready = 0 while rst is asserted; pins = 0x00, rsp_valid = 0, err_count = 0; req_ready = 1 in the first cycle after rst deasserts.
- Add, SETTLE_CYCLES = 2: opcode 0, op1 = 63, op2 = 63, tile model returns 0x7E -> pin_a_out = 0xFF, pin_b_out = 0x0F from the cycle after accept; rsp_valid 2 cycles after accept; rsp_result = 0x7E, checked = 1, mismatch = 0.
- Sub wrap: opcode 1, op1 = 5, op2 = 9, tile returns 0xFC -> pin_a_out = 0x05, pin_b_out = 0x19; rsp_result = 0xFC, mismatch = 0.
- Unchecked / mismatch: opcode 2 with tile result 0x55 -> checked = 0, mismatch = 0, err_count unchanged. Then opcode 0, 1+1 with tile forced to 0x03 -> mismatch = 1, err_count = 1; after 300 such forced mismatches err_count = 255.
- Backpressure: hold rsp_ready = 0 for 5 cycles -> rsp_valid and rsp_result stable, req_ready = 0; rsp_ready = 1 for 1 cycle -> rsp_valid low next cycle, req_ready high.
- Reset mid-SETTLE (SETTLE_CYCLES = 4, rst asserted on cycle 2) -> no rsp_valid, pins = 0x00, back in IDLE.
